tx_uart_128: RTL and testbench

Transmit-side companion of the 128-bit UART receive path. It accepts one 128-bit word on a start strobe and serializes it onto `u_tx` as 16 back-to-back 8N1 UART frames. The most significant byte is sent first, so the receive side's left-shift assembly rebuilds the original word. It sits directly upstream of the receive path and drives its serial input.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_byte.sv | 101 ++++++++++
 rtl/tx_uart_128.sv | 83 ++++++++
 tb/tb_tx_uart_128.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 128-bit UART path: frame FSM encoding and
// word/frame geometry used by both the transmitter and its bench.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_e;

  localparam int BYTES_PER_WORD = 16;
  localparam int BITS_PER_FRAME = 10;

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 byte transmitter. A tx_start seen in the final stop-bit cycle
// chains the next frame directly, so consecutive bytes have no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       tx_done_o
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign tx_done_o = (state_q == STOP_BIT) && bit_end;
  assign tx_o      = tx_q;

  // The line value is decided one cycle ahead so tx_o comes straight from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start_i) begin
          state_d = START_BIT;
          baud_d  = '0;
          byte_d  = tx_data_i;
          tx_d    = 1'b0;
        end
      end
      START_BIT: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          state_d = DATA_BITS;
          bit_d   = 3'd0;
          tx_d    = byte_q[0];
        end
      end
      DATA_BITS: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          byte_d = {1'b0, byte_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = byte_q[1];
          end
        end
      end
      STOP_BIT: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (tx_start_i) begin
            state_d = START_BIT;
            byte_d  = tx_data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/tx_uart_128.sv
// Serializes a 128-bit word as 16 back-to-back 8N1 frames, most significant
// byte first, for the 128-bit UART receive path.
module tx_uart_128
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] data_in,
  output logic         u_tx,
  output logic         busy,
  output logic         u_tx_done
);

  localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_WORD - 1);

  logic [127:0] shreg_q, shreg_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         tx_start;
  logic [7:0]   tx_byte;
  logic         tx_done;

  // The next byte is handed over in the stop-bit's last cycle, keeping frames gapless.
  always_comb begin
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tx_start = 1'b0;
    tx_byte  = shreg_q[119:112];
    if (!busy_q) begin
      if (start) begin
        shreg_d  = data_in;
        cnt_d    = 4'd0;
        busy_d   = 1'b1;
        tx_start = 1'b1;
        tx_byte  = data_in[127:120];
      end
    end else if (tx_done) begin
      shreg_d = {shreg_q[119:0], 8'h00};
      cnt_d   = cnt_q + 4'd1;
      if (cnt_q == LAST_BYTE) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        tx_start = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_start_i(tx_start),
    .tx_data_i (tx_byte),
    .tx_o      (u_tx),
    .tx_done_o (tx_done)
  );

  assign busy      = busy_q;
  assign u_tx_done = done_q;

endmodule

// File: tb/tb_tx_uart_128.sv
// Bench for tx_uart_128 at 4 clocks per bit: line waveform model, frame decoder,
// table of words plus hand-written busy, back-to-back, reset and random sequences.
module tb_tx_uart_128;
  import uart_pkg::*;

  localparam int CPB          = 4;
  localparam int FRAME_CYCLES = BITS_PER_FRAME * CPB;
  localparam int WORD_CYCLES  = BYTES_PER_WORD * FRAME_CYCLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] data_in = '0;
  logic         u_tx;
  logic         busy;
  logic         u_tx_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] word;
    int           pulseAt;
    logic [127:0] other;
  } vec_t;

  vec_t vecs[4];

  tx_uart_128 #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .u_tx     (u_tx),
    .busy     (busy),
    .u_tx_done(u_tx_done)
  );

  always #5 clk = ~clk;

  // Line level k cycles after acceptance: each 10-bit frame is 0, the byte LSB first, then 1.
  function automatic logic expLine(input logic [127:0] word, input int k);
    int         f;
    int         pos;
    logic [7:0] b;
    if (k >= WORD_CYCLES) return 1'b1;
    f   = k / FRAME_CYCLES;
    pos = (k % FRAME_CYCLES) / CPB;
    b   = word[127 - 8*f -: 8];
    if (pos == 0) return 1'b0;
    if (pos == BITS_PER_FRAME - 1) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Raise start with a word; returns at the sample point of the first cycle after acceptance.
  task automatic applyStimulus(input logic [127:0] word, input bit hold);
    data_in = word;
    start   = 1'b1;
    nextCycle();
    if (!hold) start = 1'b0;
  endtask

  task automatic idleCheck(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      checkOutput($sformatf("%s idle line %0d", tag, i), u_tx, 1'b1);
      checkOutput($sformatf("%s idle busy %0d", tag, i), busy, 1'b0);
      checkOutput($sformatf("%s idle done %0d", tag, i), u_tx_done, 1'b0);
    end
  endtask

  // Follows one word from cycle 0 to the done cycle (cycle 640), then decodes the line.
  task automatic observeWord(input logic [127:0] word, input string tag, input int pulseAt,
                             input logic [127:0] otherData, input bit holdNext,
                             input logic [127:0] nextWord);
    logic [BITS_PER_FRAME*BYTES_PER_WORD-1:0] mid;
    logic [127:0] rebuilt;
    logic [7:0]   byteVal;
    logic         framing;
    mid = '0;
    if (holdNext) begin
      start   = 1'b1;
      data_in = nextWord;
    end
    for (int k = 0; k < WORD_CYCLES; k++) begin
      checkOutput($sformatf("%s line k=%0d", tag, k), u_tx, expLine(word, k));
      checkOutput($sformatf("%s busy k=%0d", tag, k), busy, 1'b1);
      checkOutput($sformatf("%s done k=%0d", tag, k), u_tx_done, 1'b0);
      if (k % CPB == CPB / 2) mid[k/CPB] = u_tx;
      if (pulseAt >= 0 && k == pulseAt) begin
        start   = 1'b1;
        data_in = otherData;
      end else if (pulseAt >= 0 && k == pulseAt + 1) begin
        start   = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
      end
      nextCycle();
    end
    checkOutput({tag, " end busy"}, busy, 1'b0);
    checkOutput({tag, " end done"}, u_tx_done, 1'b1);
    checkOutput({tag, " end line"}, u_tx, 1'b1);
    rebuilt = '0;
    framing = 1'b1;
    for (int f = 0; f < BYTES_PER_WORD; f++) begin
      if (mid[BITS_PER_FRAME*f] !== 1'b0 || mid[BITS_PER_FRAME*f + 9] !== 1'b1) framing = 1'b0;
      for (int b = 0; b < 8; b++) byteVal[b] = mid[BITS_PER_FRAME*f + 1 + b];
      rebuilt = {rebuilt[119:0], byteVal};
    end
    checkOutput({tag, " framing"}, framing, 1'b1);
    checkOutput({tag, " decoded word"}, rebuilt, word);
  endtask

  initial begin
    logic [127:0] w1;
    logic [127:0] w2;

    vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, -1, '0};
    vecs[1] = '{{16{8'hA5}}, -1, '0};
    vecs[2] = '{128'h0123456789ABCDEF0123456789ABCDEF, -1, '0};
    vecs[3] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 100,
                128'hFFEEDDCC_BBAA9988_77665544_33221100};

    // Reset held low, then released with start never raised.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset line", u_tx, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", u_tx_done, 1'b0);
    rst_n = 1'b1;
    idleCheck("post-reset", 100);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].word, 1'b0);
      observeWord(vecs[i].word, $sformatf("vec%0d", i), vecs[i].pulseAt, vecs[i].other,
                  1'b0, '0);
      idleCheck($sformatf("vec%0d after", i), 50);
    end

    // Start held through the done cycle: the next word is accepted at the edge ending it.
    w1 = {$urandom, $urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(w1, 1'b1);
    observeWord(w1, "b2b first", -1, '0, 1'b1, w2);
    nextCycle();
    start = 1'b0;
    observeWord(w2, "b2b second", -1, '0, 1'b0, '0);
    idleCheck("b2b after", 20);

    // Reset asserted partway through the second frame.
    w1 = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(w1, 1'b0);
    for (int k = 0; k < 57; k++) nextCycle();
    checkOutput("pre-reset line k=57", u_tx, expLine(w1, 57));
    checkOutput("pre-reset busy k=57", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset line", u_tx, 1'b1);
    checkOutput("mid-reset busy", busy, 1'b0);
    checkOutput("mid-reset done", u_tx_done, 1'b0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    idleCheck("mid-reset release", 100);
    applyStimulus(w1, 1'b0);
    observeWord(w1, "after-reset", -1, '0, 1'b0, '0);

    // Random words, gaps and spurious starts while busy.
    for (int r = 0; r < 4; r++) begin
      int gap;
      int pulse;
      gap   = $urandom_range(0, 6);
      pulse = ($urandom_range(0, 1) == 1) ? $urandom_range(1, WORD_CYCLES - 3) : -1;
      w1    = {$urandom, $urandom, $urandom, $urandom};
      w2    = {$urandom, $urandom, $urandom, $urandom};
      idleCheck($sformatf("rand%0d gap", r), gap);
      applyStimulus(w1, 1'b0);
      observeWord(w1, $sformatf("rand%0d", r), pulse, w2, 1'b0, '0);
    end
    idleCheck("final", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
